// File: rtl/jtag_axi_req_arb.sv
// Round-robin arbiter feeding a single-outstanding dispatch engine.
// Owns one request at a time through issue, response wait (with timeout) and routed reply.
module jtag_axi_req_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CC = 4096
) (
  input  logic                          clk,
  input  logic                          aresn,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic                          m_valid_o,
  output logic                          m_wr_o,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  input  logic                          m_ready_i,
  input  logic                          m_resp_valid_i,
  input  logic [1:0]                    m_resp_i,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [1:0]                    rsp_resp_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          rsp_timeout_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CC) + 1;
  // Last WAIT cycle count before the counter would reach TIMEOUT_CC-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CC - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tmo_q, tmo_d;

  logic                  sel_found;
  logic [GW-1:0]         sel_idx;
  logic                  resp_done;

  function automatic logic [GW-1:0] rr_pos(input logic [GW-1:0] last, input int off);
    int p;
    p = int'(last) + off;
    if (p >= NUM_REQ) p = p - NUM_REQ;
    return p[GW-1:0];
  endfunction

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!sel_found && req_valid_i[rr_pos(last_grant_q, i)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_pos(last_grant_q, i);
      end
    end
  end

  assign resp_done = m_resp_valid_i || (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_found) state_d = ISSUE;
      ISSUE:   if (m_ready_i) state_d = WAIT;
      WAIT:    if (resp_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    m_valid_o   = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        // Gated by reset so no acceptance is advertised while the block is held.
        if (sel_found && aresn) req_ready_o[sel_idx] = 1'b1;
      end
      ISSUE:   m_valid_o = 1'b1;
      RESP:    rsp_valid_o[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    tmo_d        = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          wr_d    = req_wr_i[sel_idx];
          addr_d  = req_addr_i[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ISSUE: if (m_ready_i) cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A real response beats a timeout landing on the same cycle.
        if (m_resp_valid_i) begin
          resp_d  = m_resp_i;
          rdata_d = m_rdata_i;
          tmo_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = 2'b10;
          rdata_d = '0;
          tmo_d   = 1'b1;
        end
      end
      RESP:    last_grant_d = grant_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
      tmo_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      tmo_q        <= tmo_d;
    end
  end

  assign m_wr_o        = wr_q;
  assign m_addr_o      = addr_q;
  assign m_wdata_o     = wdata_q;
  assign rsp_resp_o    = resp_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_timeout_o = tmo_q;
  assign grant_id_o    = grant_q;

endmodule

// File: tb/tb_jtag_axi_req_arb.sv
// Bench for jtag_axi_req_arb: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_jtag_axi_req_arb;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int GW  = $clog2(N);

  logic            clk = 1'b0;
  logic            aresn;
  logic [N-1:0]    req_valid_i, req_ready_o, req_wr_i, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic            m_valid_o, m_wr_o, m_ready_i, m_resp_valid_i;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o, m_rdata_i, rsp_rdata_o;
  logic [1:0]      m_resp_i, rsp_resp_o;
  logic            rsp_timeout_o, busy_o;
  logic [GW-1:0]   grant_id_o;

  jtag_axi_req_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CC(TMO)) dut (
    .clk(clk), .aresn(aresn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .m_valid_o(m_valid_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ready_i(m_ready_i), .m_resp_valid_i(m_resp_valid_i), .m_resp_i(m_resp_i),
    .m_rdata_i(m_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_resp_o(rsp_resp_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one live transaction with milestones and timestamps.
  bit          t_live = 0, t_sent = 0, t_done = 0;
  int          t_last = N - 1, t_grant = 0, t_hs = 0, cyc = 0;
  logic          p_wr = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0, r_rdata = '0;
  logic [1:0]    r_resp = '0;
  logic          r_tmo = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int lst, input logic [N-1:0] v);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (lst + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    t_live = 0; t_sent = 0; t_done = 0; t_last = N - 1; t_grant = 0;
    p_wr = 0; p_addr = '0; p_wdata = '0; r_resp = '0; r_rdata = '0; r_tmo = 0;
  endtask

  task automatic model_cycle();
    logic [N-1:0] e_ready, e_rsp;
    int p;
    if (!aresn) model_reset();
    e_ready = '0;
    e_rsp   = '0;
    p = rr_pick(t_last, req_valid_i);
    if (aresn && !t_live && p >= 0) e_ready[p] = 1'b1;
    if (t_done) e_rsp[t_grant] = 1'b1;
    chk("req_ready", req_ready_o, e_ready);
    chk("m_valid", m_valid_o, t_live && !t_sent);
    chk("m_wr", m_wr_o, p_wr);
    chk("m_addr", m_addr_o, p_addr);
    chk("m_wdata", m_wdata_o, p_wdata);
    chk("rsp_valid", rsp_valid_o, e_rsp);
    chk("rsp_resp", rsp_resp_o, r_resp);
    chk("rsp_rdata", rsp_rdata_o, r_rdata);
    chk("rsp_timeout", rsp_timeout_o, r_tmo);
    chk("busy", busy_o, t_live);
    chk("grant_id", grant_id_o, 64'(t_grant));
    if (aresn) begin
      if (!t_live) begin
        if (p >= 0) begin
          t_grant = p; p_wr = req_wr_i[p];
          p_addr = req_addr_i[p*AW +: AW]; p_wdata = req_wdata_i[p*DW +: DW];
          t_live = 1; t_sent = 0; t_done = 0;
        end
      end else if (!t_sent) begin
        if (m_ready_i) begin t_sent = 1; t_hs = cyc; end
      end else if (!t_done) begin
        if (m_resp_valid_i) begin
          r_resp = m_resp_i; r_rdata = m_rdata_i; r_tmo = 0; t_done = 1;
        end else if (cyc - t_hs == TMO - 1) begin
          r_resp = 2'b10; r_rdata = '0; r_tmo = 1; t_done = 1;
        end
      end else begin
        t_last = t_grant; t_live = 0; t_done = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid_i = '0; m_ready_i = 1; m_resp_valid_i = 1; m_resp_i = 0;
    for (int k = 0; k < 40 && busy_o; k++) tick();
    m_resp_valid_i = 0;
    #1;
    chk("drain_idle", busy_o, 0);
  endtask

  task automatic run_tmo(input int resp_at, output int n, output logic got);
    req_valid_i = 2'b01; m_ready_i = 1; m_resp_valid_i = 0;
    tick();
    req_valid_i = '0;
    tick();
    m_ready_i = 0;
    n = 1; got = 0;
    while (n < 40 && !got) begin
      m_resp_valid_i = (n == resp_at); m_resp_i = 2'b01; m_rdata_i = 32'h12345678;
      #1;
      if (rsp_valid_o != '0) got = 1;
      else begin tick(); n++; end
    end
    m_resp_valid_i = 0;
  endtask

  initial begin
    int ng, nr, n;
    logic got;
    aresn = 0; req_valid_i = 2'b11; req_wr_i = '0; req_addr_i = '0; req_wdata_i = '0;
    m_ready_i = 0; m_resp_valid_i = 0; m_resp_i = 0; m_rdata_i = '0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_grant", grant_id_o, 0);
    tick(); tick();
    aresn = 1; req_valid_i = '0;
    tick();

    // Single read, minimum latency.
    req_valid_i = 2'b01; req_addr_i[0 +: AW] = 32'h1000; m_ready_i = 1;
    #1; chk("acc_ready", req_ready_o, 2'b01);
    tick(); req_valid_i = '0;
    #1; chk("t1_m_valid", m_valid_o, 1); chk("t1_m_addr", m_addr_o, 32'h1000);
    tick();
    m_resp_valid_i = 1; m_resp_i = 0; m_rdata_i = 32'hDEADBEEF;
    tick(); m_resp_valid_i = 0;
    #1; chk("t3_rsp_valid", rsp_valid_o, 2'b01); chk("t3_rdata", rsp_rdata_o, 32'hDEADBEEF);
    chk("t3_tmo", rsp_timeout_o, 0);
    tick();
    #1; chk("t4_busy", busy_o, 0);

    // Round-robin alternation from reset.
    aresn = 0; tick(); aresn = 1; tick();
    req_valid_i = 2'b11; m_ready_i = 1; m_resp_valid_i = 1; m_rdata_i = $urandom;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      if (req_ready_o != '0) begin
        chk("rr_grant", req_ready_o, (ng % 2 == 0) ? 2'b01 : 2'b10); ng++;
      end
      if (rsp_valid_o != '0) begin
        chk("rr_owner", rsp_valid_o, ((ng - 1) % 2 == 0) ? 2'b01 : 2'b10); nr++;
      end
      tick();
    end
    chk("rr_count", nr, 4);
    drain();

    // Dispatch stall: payload held, no further acceptance.
    req_valid_i = 2'b11; req_addr_i[0 +: AW] = 32'hA5A50000; m_ready_i = 0; m_resp_valid_i = 0;
    #1; chk("stall_acc", req_ready_o, 2'b01);
    tick();
    for (int k = 0; k < 5; k++) begin
      req_addr_i = {$urandom, $urandom};
      #1;
      chk("stall_m_valid", m_valid_o, 1);
      chk("stall_addr", m_addr_o, 32'hA5A50000);
      chk("stall_ready", req_ready_o, 0);
      tick();
    end
    drain();

    // Timeout, then response on the timeout cycle.
    run_tmo(-1, n, got);
    chk("tmo_got", got, 1); chk("tmo_lat", n, 16); chk("tmo_resp", rsp_resp_o, 2'b10);
    chk("tmo_flag", rsp_timeout_o, 1); chk("tmo_rdata", rsp_rdata_o, 0);
    tick();
    run_tmo(15, n, got);
    chk("race_lat", n, 16); chk("race_flag", rsp_timeout_o, 0);
    chk("race_resp", rsp_resp_o, 2'b01); chk("race_rdata", rsp_rdata_o, 32'h12345678);
    tick();

    // Reset during WAIT, stray responses in IDLE, first grant after reset.
    req_valid_i = 2'b01; m_ready_i = 1;
    tick(); req_valid_i = '0; tick(); tick(); tick();
    aresn = 0;
    #1; chk("wrst_busy", busy_o, 0); chk("wrst_rsp", rsp_valid_o, 0);
    tick();
    aresn = 1; m_resp_valid_i = 1; m_resp_i = 2'b11; m_rdata_i = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      #1; chk("stray_busy", busy_o, 0); chk("stray_rsp", rsp_valid_o, 0);
      chk("stray_rdata", rsp_rdata_o, 0);
      tick();
    end
    m_resp_valid_i = 0; req_valid_i = 2'b11;
    #1; chk("post_rst_grant", req_ready_o, 2'b01);
    tick();
    drain();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      aresn = ($urandom_range(0, 299) != 0);
      req_valid_i = N'($urandom); req_wr_i = N'($urandom);
      req_addr_i = {$urandom, $urandom}; req_wdata_i = {$urandom, $urandom};
      m_ready_i = ($urandom_range(0, 9) < 6);
      m_resp_valid_i = ($urandom_range(0, 9) < 2);
      m_resp_i = 2'($urandom); m_rdata_i = $urandom;
      tick();
    end
    aresn = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
